// File: rtl/card_reader.sv
// Metro turnstile card front end: debounces card presence, deserialises the
// start/data/parity balance frame and holds a checked balance until removal.
module card_reader #(
  parameter int BAL_W           = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             card_sense,
  input  logic             card_data,
  output logic             card_inserted,
  output logic [BAL_W-1:0] balance,
  output logic             read_error,
  output logic             busy
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BAL_W + 1);
  localparam int FW = BAL_W + 1;  // data bits plus parity bit

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    SHIFT      = 3'd2,
    CHECK      = 3'd3,
    VALID      = 3'd4,
    ERROR      = 3'd5
  } state_t;

  state_t           state, state_next;
  logic             card_present;
  logic [DW-1:0]    deb_cnt;
  logic [TW-1:0]    tmo_cnt, tmo_cnt_next;
  logic [BW-1:0]    bit_cnt, bit_cnt_next;
  logic [FW-1:0]    shreg, shreg_next;
  logic [BAL_W-1:0] balance_next;

  // Presence flips only after DEBOUNCE_CYCLES consecutive opposite samples.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      card_present <= 1'b0;
      deb_cnt      <= '0;
    end else if (card_sense != card_present) begin
      if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        card_present <= ~card_present;
        deb_cnt      <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next   = state;
    tmo_cnt_next = tmo_cnt;
    bit_cnt_next = bit_cnt;
    shreg_next   = shreg;
    balance_next = balance;
    case (state)
      IDLE: begin
        if (card_present) begin
          state_next   = WAIT_START;
          tmo_cnt_next = '0;
        end
      end
      WAIT_START: begin
        // Removal outranks the start bit and the timeout.
        if (!card_present) begin
          state_next = IDLE;
        end else if (card_data) begin
          state_next   = SHIFT;
          bit_cnt_next = '0;
        end else begin
          tmo_cnt_next = tmo_cnt + 1'b1;
          if (tmo_cnt_next == TW'(TIMEOUT_CYCLES)) state_next = ERROR;
        end
      end
      SHIFT: begin
        if (!card_present) begin
          state_next = IDLE;
        end else begin
          shreg_next = {shreg[FW-2:0], card_data};
          if (bit_cnt == BW'(BAL_W)) begin
            state_next = CHECK;
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
      end
      CHECK: begin
        if (!card_present) begin
          state_next = IDLE;
        end else if (^shreg == 1'b0) begin
          state_next   = VALID;
          balance_next = shreg[FW-1:1];
        end else begin
          state_next = ERROR;
        end
      end
      VALID, ERROR: begin
        if (!card_present) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      balance <= '0;
    end else begin
      state   <= state_next;
      tmo_cnt <= tmo_cnt_next;
      bit_cnt <= bit_cnt_next;
      shreg   <= shreg_next;
      balance <= balance_next;
    end
  end

  assign card_inserted = (state == VALID);
  assign read_error    = (state == ERROR);
  assign busy          = (state == WAIT_START) || (state == SHIFT) || (state == CHECK);

endmodule

// File: tb/tb_card_reader.sv
// Self-checking bench for card_reader: table of frames through a scoreboard,
// plus hand sequences for debounce glitches, timeout, removal and reset.
module tb_card_reader;

  localparam int BAL_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             card_sense;
  logic             card_data;
  logic             card_inserted;
  logic [BAL_W-1:0] balance;
  logic             read_error;
  logic             busy;

  card_reader #(.BAL_W(BAL_W), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(15)) dut (
    .clk           (clk),
    .reset         (reset),
    .card_sense    (card_sense),
    .card_data     (card_data),
    .card_inserted (card_inserted),
    .balance       (balance),
    .read_error    (read_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BAL_W-1:0] data;
    logic             parity;
    logic             exp_ok;
    logic [BAL_W-1:0] exp_bal;
  } vec_t;

  typedef struct {
    logic             ok;
    logic [BAL_W-1:0] bal;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Four sense-high edges raise card_present; the fifth moves IDLE->WAIT_START.
  task automatic insert_card(input string tag);
    card_sense = 1'b1;
    repeat (4) tick();
    check({tag, "_busy_before_debounce"}, busy, 0);
    tick();
    check({tag, "_busy_wait_start"}, busy, 1);
  endtask

  task automatic remove_card(input string tag, input logic was_ok);
    card_sense = 1'b0;
    card_data  = 1'b0;
    repeat (4) tick();
    check({tag, "_held_until_debounced"}, card_inserted | read_error, 1);
    tick();
    check({tag, "_inserted_after_removal"}, card_inserted, 0);
    check({tag, "_error_after_removal"}, read_error, 0);
    check({tag, "_busy_after_removal"}, busy, 0);
    if (!was_ok) check({tag, "_was_error"}, read_error, 0);
  endtask

  // Drives start bit, data MSB first and parity; leaves the DUT in CHECK.
  task automatic send_frame(input logic [BAL_W-1:0] data, input logic parity);
    logic [BAL_W+1:0] frame;
    frame = {1'b1, data, parity};
    for (int i = BAL_W + 1; i >= 0; i--) begin
      card_data = frame[i];
      tick();
    end
    card_data = 1'b0;
  endtask

  task automatic wait_result(input string tag, output exp_t e);
    int n;
    n = 0;
    while (!(card_inserted || read_error) && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 1);
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 1, 0);
      e.ok  = 1'b0;
      e.bal = '0;
    end else begin
      e = sb.pop_front();
      check({tag, "_inserted"}, card_inserted, e.ok);
      check({tag, "_read_error"}, read_error, !e.ok);
      check({tag, "_balance"}, balance, e.bal);
      check({tag, "_busy"}, busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    exp_t e;
    logic stable;
    logic seen;
    string tag;

    vecs[0] = '{data: 3'b101, parity: 1'b0, exp_ok: 1'b1, exp_bal: 3'b101};
    vecs[1] = '{data: 3'b100, parity: 1'b1, exp_ok: 1'b1, exp_bal: 3'b100};
    vecs[2] = '{data: 3'b101, parity: 1'b1, exp_ok: 1'b0, exp_bal: 3'b100};
    vecs[3] = '{data: 3'b000, parity: 1'b0, exp_ok: 1'b1, exp_bal: 3'b000};
    vecs[4] = '{data: 3'b111, parity: 1'b1, exp_ok: 1'b1, exp_bal: 3'b111};
    vecs[5] = '{data: 3'b011, parity: 1'b1, exp_ok: 1'b0, exp_bal: 3'b111};
    vecs[6] = '{data: 3'b010, parity: 1'b1, exp_ok: 1'b1, exp_bal: 3'b010};

    reset      = 1'b1;
    card_sense = 1'b0;
    card_data  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_inserted", card_inserted, 0);
    check("reset_balance", balance, 0);
    check("reset_error", read_error, 0);
    check("reset_busy", busy, 0);

    // Bouncy sense: 1,1,0,1,1,0 must never debounce to present.
    seen = 1'b0;
    foreach (vecs[i]) begin
      if (i < 6) begin
        card_sense = (i == 2 || i == 5) ? 1'b0 : 1'b1;
        card_data  = 1'b1;
        tick();
        seen |= busy | card_inserted | read_error;
      end
    end
    card_data = 1'b0;
    repeat (6) begin
      tick();
      seen |= busy | card_inserted | read_error;
    end
    check("glitch_no_activity", seen, 0);

    for (int i = 0; i < 7; i++) begin
      tag = $sformatf("v%0d", i);
      insert_card(tag);
      send_frame(vecs[i].data, vecs[i].parity);
      sb.push_back('{ok: vecs[i].exp_ok, bal: vecs[i].exp_bal});
      check({tag, "_check_busy"}, busy, 1);
      check({tag, "_check_not_inserted"}, card_inserted, 0);
      wait_result(tag, e);
      // Hold with noise on the data line: nothing may change or retrigger.
      stable = 1'b1;
      for (int c = 0; c < 20; c++) begin
        card_data = 1'($urandom_range(0, 1));
        tick();
        if (card_inserted !== e.ok || read_error !== !e.ok || balance !== e.bal || busy !== 1'b0)
          stable = 1'b0;
      end
      check({tag, "_hold_stable"}, stable, 1);
      remove_card(tag, e.ok);
      check({tag, "_balance_persists"}, balance, e.bal);
    end

    // Timeout: data held low for TIMEOUT_CYCLES edges in WAIT_START.
    insert_card("tmo");
    card_data = 1'b0;
    repeat (14) tick();
    check("tmo_not_yet_error", read_error, 0);
    check("tmo_still_busy", busy, 1);
    tick();
    check("tmo_error", read_error, 1);
    check("tmo_busy_clear", busy, 0);
    check("tmo_not_inserted", card_inserted, 0);
    remove_card("tmo", 1'b0);
    check("tmo_balance_kept", balance, 3'b010);

    // Removal mid-SHIFT: sense drops with the start bit, present falls during SHIFT.
    insert_card("rem");
    card_sense = 1'b0;
    send_frame(3'b110, 1'b0);
    check("rem_busy", busy, 0);
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= card_inserted | read_error | busy;
    end
    check("rem_no_result", seen, 0);
    check("rem_balance_kept", balance, 3'b010);

    // Reset mid-SHIFT, then a fresh read.
    insert_card("rst");
    card_data = 1'b1;
    tick();
    card_data = 1'b0;
    tick();
    card_data = 1'b1;
    tick();
    reset      = 1'b1;
    card_sense = 1'b0;
    card_data  = 1'b0;
    tick();
    reset = 1'b0;
    check("rst_shift_busy", busy, 0);
    check("rst_shift_inserted", card_inserted, 0);
    check("rst_shift_error", read_error, 0);
    check("rst_shift_balance", balance, 0);
    repeat (3) tick();
    check("rst_idle_busy", busy, 0);
    insert_card("rst2");
    send_frame(3'b110, 1'b0);
    sb.push_back('{ok: 1'b1, bal: 3'b110});
    wait_result("rst2", e);

    // Reset while VALID clears everything including balance.
    reset      = 1'b1;
    card_sense = 1'b0;
    tick();
    reset = 1'b0;
    check("rst_valid_inserted", card_inserted, 0);
    check("rst_valid_balance", balance, 0);
    check("rst_valid_busy", busy, 0);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
